// File: rtl/vga_layer_renderer.sv
// vga_layer_renderer: 2-stage pixel renderer (border > player > obstacle > background) with frame-latched scene and overlap flag.
// Optional VGA_PAUSE_BLINK_EN: blink the player while paused.
module vga_layer_renderer #(
  parameter int N_OBS       = 10,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int UPPER_BOUND = 20,
  parameter int LOWER_BOUND = 460,
  parameter int BLINK_LOG2  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid,
  input  logic [9:0]          pix_x,
  input  logic [8:0]          pix_y,
  input  logic                frame_start,
  input  logic [1:0]          gamemode,
  input  logic [8:0]          player_y,
  input  logic [N_OBS*20-1:0] obstacle_x,
  input  logic [N_OBS*18-1:0] obstacle_y,
  output logic [11:0]         rgb,
  output logic                rgb_valid,
  output logic                collision
);
  localparam logic [9:0] PX_LO = 10'(PLAYER_X);
  localparam logic [9:0] PX_HI = 10'(PLAYER_X + PLAYER_SIZE);
  localparam logic [9:0] PSZ   = 10'(PLAYER_SIZE);
  localparam logic [8:0] Y_UB  = 9'(UPPER_BOUND);
  localparam logic [8:0] Y_LB  = 9'(LOWER_BOUND);
  logic [1:0]          sh_mode;
  logic [8:0]          sh_py;
  logic [N_OBS*20-1:0] sh_ox;
  logic [N_OBS*18-1:0] sh_oy;
  logic [9:0]          py_end;
  logic                border_c, player_c, obs_c, hide_c, hit;
  logic                v1, border1, pl1, obs1, hide1;
  logic [1:0]          mode1;
  logic                acc, draw;
  logic [11:0]         bg, rgb_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_mode <= '0;
      sh_py   <= '0;
      sh_ox   <= '0;
      sh_oy   <= '0;
    end else if (frame_start) begin
      sh_mode <= gamemode;
      sh_py   <= player_y;
      sh_ox   <= obstacle_x;
      sh_oy   <= obstacle_y;
    end
  // player bottom edge is widened to 10 bits so it never wraps past row 511
  assign py_end = {1'b0, sh_py} + PSZ;
  always_comb begin
    border_c = pix_y <= Y_UB || pix_y >= Y_LB;
    player_c = pix_x >= PX_LO && pix_x < PX_HI && pix_y >= sh_py && {1'b0, pix_y} < py_end;
    obs_c = 1'b0;
    for (int i = 0; i < N_OBS; i++)
      obs_c = obs_c | (pix_x >= sh_ox[i*20+10 +: 10] && pix_x < sh_ox[i*20 +: 10] &&
                       pix_y >= sh_oy[i*18+9 +: 9] && pix_y < sh_oy[i*18 +: 9]);
  end
`ifdef VGA_PAUSE_BLINK_EN
  logic [BLINK_LOG2:0] frame_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 1'b1;
  assign hide_c = sh_mode == 2'b10 && frame_cnt[BLINK_LOG2];
`else
  assign hide_c = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1      <= 1'b0;
      border1 <= 1'b0;
      pl1     <= 1'b0;
      obs1    <= 1'b0;
      hide1   <= 1'b0;
      mode1   <= '0;
    end else begin
      v1      <= pix_valid;
      border1 <= border_c;
      pl1     <= player_c;
      obs1    <= obs_c;
      hide1   <= hide_c;
      mode1   <= sh_mode;
    end
  // overlap uses the raw player shape: a blinked-out player still collides
  assign hit = v1 && pl1 && obs1 && sh_mode == 2'b01;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= acc | hit;
      acc       <= 1'b0;
    end else begin
      acc       <= acc | hit;
    end
  assign draw    = mode1 != 2'b00;
  assign bg      = mode1 == 2'b00 ? 12'h0F0 : mode1 == 2'b01 ? 12'hFFF : mode1 == 2'b10 ? 12'hFF0 : 12'hF00;
  assign rgb_nxt = !v1 || border1 ? 12'h000 : draw && pl1 && !hide1 ? 12'h00F : draw && obs1 ? 12'hFA0 : bg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= rgb_nxt;
      rgb_valid <= v1;
    end
endmodule

// File: tb/tb_vga_layer_renderer.sv
// tb_vga_layer_renderer: directed checks of colours, priorities, shadow latching, collision and reset.
module tb_vga_layer_renderer;
  localparam int N_OBS = 10;
`ifdef VGA_PAUSE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                pix_valid = 1'b0;
  logic [9:0]          pix_x = '0;
  logic [8:0]          pix_y = '0;
  logic                frame_start = 1'b0;
  logic [1:0]          gamemode = '0;
  logic [8:0]          player_y = '0;
  logic [N_OBS*20-1:0] obstacle_x = '0;
  logic [N_OBS*18-1:0] obstacle_y = '0;
  logic [11:0]         rgb;
  logic                rgb_valid;
  logic                collision;
  int checks = 0;
  int errors = 0;
  int fc = 0;
  vga_layer_renderer dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .gamemode(gamemode), .player_y(player_y),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .rgb(rgb), .rgb_valid(rgb_valid), .collision(collision)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic fs(input logic [1:0] m, input logic [8:0] py);
    @(negedge clk);
    gamemode = m;
    player_y = py;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fc++;
  endtask
  task automatic set_obs(input int i, input logic [9:0] l, input logic [9:0] r, input logic [8:0] t, input logic [8:0] b);
    obstacle_x[i*20 +: 20] = {l, r};
    obstacle_y[i*18 +: 18] = {t, b};
  endtask
  task automatic pixel(input string tag, input logic [9:0] x, input logic [8:0] y, input logic [11:0] exp);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = x;
    pix_y = y;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    chk(tag, rgb, exp);
    chk({tag, "_valid"}, {11'd0, rgb_valid}, 12'd1);
  endtask
  logic [9:0]  bx [5] = '{10'd300, 10'd305, 10'd170, 10'd305, 10'd500};
  logic [8:0]  by [5] = '{9'd245, 9'd245, 9'd210, 9'd150, 9'd10};
  logic [11:0] be [5] = '{12'hFFF, 12'hFFF, 12'h00F, 12'hFA0, 12'h000};
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_valid", {11'd0, rgb_valid}, 12'd0);
    chk("rst_coll", {11'd0, collision}, 12'd0);
    rst_n = 1'b1;
    pixel("init_bg", 10'd100, 9'd100, 12'h0F0);
    @(negedge clk);
    chk("idle_rgb", rgb, 12'h000);
    chk("idle_valid", {11'd0, rgb_valid}, 12'd0);
    // shadow latching and player edges
    fs(2'b01, 9'd200);
    player_y = 9'd300;
    pixel("pl_in", 10'd170, 9'd210, 12'h00F);
    pixel("pl_unlatched", 10'd170, 9'd310, 12'hFFF);
    pixel("pl_left_out", 10'd159, 9'd210, 12'hFFF);
    pixel("pl_corner", 10'd199, 9'd239, 12'h00F);
    pixel("pl_right_out", 10'd200, 9'd210, 12'hFFF);
    pixel("pl_bottom_out", 10'd170, 9'd240, 12'hFFF);
    // full-height obstacle against the borders
    set_obs(0, 10'd300, 10'd340, 9'd0, 9'd480);
    fs(2'b01, 9'd200);
    pixel("ob_y20", 10'd310, 9'd20, 12'h000);
    pixel("ob_y21", 10'd310, 9'd21, 12'hFA0);
    pixel("ob_y459", 10'd310, 9'd459, 12'hFA0);
    pixel("ob_y460", 10'd310, 9'd460, 12'h000);
    pixel("ob_x339", 10'd339, 9'd100, 12'hFA0);
    pixel("ob_x340", 10'd340, 9'd100, 12'hFFF);
    // collision accumulate / report / clear
    set_obs(0, 10'd150, 10'd180, 9'd190, 9'd230);
    fs(2'b01, 9'd200);
    chk("coll_none", {11'd0, collision}, 12'd0);
    pixel("ov_player", 10'd170, 9'd210, 12'h00F);
    pixel("ov_obs", 10'd155, 9'd195, 12'hFA0);
    fs(2'b01, 9'd200);
    chk("coll_set", {11'd0, collision}, 12'd1);
    repeat (5) @(negedge clk);
    chk("coll_hold", {11'd0, collision}, 12'd1);
    pixel("ov_again", 10'd170, 9'd210, 12'h00F);
    set_obs(0, 10'd400, 10'd420, 9'd190, 9'd230);
    fs(2'b01, 9'd200);
    chk("coll_prev", {11'd0, collision}, 12'd1);
    pixel("moved_pl", 10'd170, 9'd210, 12'h00F);
    fs(2'b01, 9'd200);
    chk("coll_clear", {11'd0, collision}, 12'd0);
    // a hit in the frame_start cycle is reported, not carried
    set_obs(0, 10'd150, 10'd180, 9'd190, 9'd230);
    fs(2'b01, 9'd200);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = 10'd170;
    pix_y = 9'd210;
    @(negedge clk);
    pix_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fc++;
    chk("coll_edge", {11'd0, collision}, 12'd1);
    fs(2'b01, 9'd200);
    chk("coll_nocarry", {11'd0, collision}, 12'd0);
    pixel("ov_pre_rst", 10'd170, 9'd210, 12'h00F);
    fs(2'b01, 9'd200);
    chk("coll_pre_rst", {11'd0, collision}, 12'd1);
    // asynchronous reset in the middle of a pixel stream
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = 10'd170;
    pix_y = 9'd210;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_valid", {11'd0, rgb_valid}, 12'd0);
    chk("mid_rst_coll", {11'd0, collision}, 12'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    fc = 0;
    pixel("post_rst_bg", 10'd100, 9'd100, 12'h0F0);
    pixel("post_rst_nopl", 10'd170, 9'd210, 12'h0F0);
    // empty rectangles and back-to-back latency
    obstacle_x = '0;
    obstacle_y = '0;
    set_obs(1, 10'd300, 10'd300, 9'd0, 9'd480);
    set_obs(2, 10'd300, 10'd340, 9'd250, 9'd240);
    set_obs(3, 10'd300, 10'd340, 9'd100, 9'd200);
    fs(2'b01, 9'd200);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("b2b_%0d", k - 2), rgb, be[k-2]);
        chk($sformatf("b2b_valid_%0d", k - 2), {11'd0, rgb_valid}, 12'd1);
      end
      if (k < 5) begin
        pix_valid = 1'b1;
        pix_x = bx[k];
        pix_y = by[k];
      end else pix_valid = 1'b0;
    end
    // paused mode over many frames
    obstacle_x = '0;
    obstacle_y = '0;
    for (int f = 0; f < 32; f++) begin
      fs(2'b10, 9'd200);
      pixel($sformatf("pause_f%0d", fc), 10'd170, 9'd210, (BLINK && fc[4]) ? 12'hFF0 : 12'h00F);
    end
    pixel("pause_bg", 10'd500, 9'd100, 12'hFF0);
    fs(2'b11, 9'd200);
    pixel("ended_bg", 10'd500, 9'd100, 12'hF00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
